// File: rtl/outbox_uart_tx_if.sv
// Reader-side handshake to the CPU OUTBOX: FWFT head byte, empty flag and pop strobe.
// The UART is the master because it decides when to pop.
interface outbox_uart_tx_if;
  logic       empty;
  logic [7:0] data;
  logic       rd;

  modport master (input empty, input data, output rd);
  modport slave  (output empty, output data, input rd);
endinterface

// File: rtl/outbox_uart_tx.sv
// Pops bytes from the OUTBOX and transmits each as a UART 8N1 frame (LSB first).
// Every output is a register, so all next values are computed one cycle ahead.
module outbox_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              en,
  outbox_uart_tx_if.master  outbox,
  output logic              tx,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic             stop_reg, stop_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             rd_reg, rd_next;
  logic             busy_reg, busy_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    stop_next  = stop_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    rd_next    = 1'b0;
    busy_next  = busy_reg;
    case (state_reg)
      S_IDLE: begin
        tx_next = 1'b1;
        // The empty flag is only looked at here; changes mid-frame are irrelevant.
        if (en && !outbox.empty) begin
          state_next = S_LOAD;
          rd_next    = 1'b1;
          busy_next  = 1'b1;
        end
      end
      S_LOAD: begin
        // Pop and latch happen on the same edge: the FWFT head is still valid now.
        shift_next = outbox.data;
        state_next = S_START;
        tx_next    = 1'b0;
        cnt_next   = '0;
      end
      S_START: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          bit_next   = 3'd0;
          tx_next    = shift_reg[0];
          state_next = S_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = S_STOP;
            stop_next  = 1'b0;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_reg + 3'd1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_STOP: begin
        tx_next = 1'b1;
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (stop_reg == STOP_LAST) begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
          end else begin
            stop_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= 3'd0;
      stop_reg  <= 1'b0;
      shift_reg <= 8'h00;
      tx_reg    <= 1'b1;
      rd_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      stop_reg  <= stop_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      rd_reg    <= rd_next;
      busy_reg  <= busy_next;
    end
  end

  assign outbox.rd = rd_reg;
  assign tx        = tx_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_outbox_uart_tx.sv
// Bench for outbox_uart_tx: two instances (4 clk/bit 1 stop, 5 clk/bit 2 stop),
// each fed by a small first-word-fall-through FIFO model.
module tb_outbox_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst = 1'b1;
  logic en_a  = 1'b1;
  logic en_b  = 1'b1;
  logic tx_a, busy_a, tx_b, busy_b;

  outbox_uart_tx_if ifa ();
  outbox_uart_tx_if ifb ();

  outbox_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .i_rst(i_rst), .en(en_a), .outbox(ifa), .tx(tx_a), .busy(busy_a)
  );
  outbox_uart_tx #(.CLKS_PER_BIT(5), .STOP_BITS(2)) dut_b (
    .clk(clk), .i_rst(i_rst), .en(en_b), .outbox(ifb), .tx(tx_b), .busy(busy_b)
  );

  // FIFO models: written by the stimulus, popped on rd
  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];
  logic [5:0] wp_a = 6'd0, rp_a = 6'd0, wp_b = 6'd0, rp_b = 6'd0;
  int pops_a = 0, pops_b = 0, busy_cyc_a = 0;

  assign ifa.empty = (wp_a == rp_a);
  assign ifa.data  = mem_a[rp_a];
  assign ifb.empty = (wp_b == rp_b);
  assign ifb.data  = mem_b[rp_b];

  always @(posedge clk) begin
    if (ifa.rd) begin
      pops_a <= pops_a + 1;
      if (wp_a != rp_a) rp_a <= rp_a + 6'd1;
    end
    if (ifb.rd) begin
      pops_b <= pops_b + 1;
      if (wp_b != rp_b) rp_b <= rp_b + 6'd1;
    end
    if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic push_a(input logic [7:0] b);
    mem_a[wp_a] = b;
    wp_a = wp_a + 6'd1;
  endtask

  // Starting at a negedge: count tx-high cycles until the start bit, then record 40 cycles.
  task automatic capture(output logic [39:0] wave, output int wait_cyc, output bit to);
    wait_cyc = 0;
    to = 1'b0;
    wave = '0;
    while (tx_a !== 1'b0) begin
      if (wait_cyc >= 300) begin
        to = 1'b1;
        return;
      end
      @(negedge clk);
      wait_cyc++;
    end
    for (int i = 0; i < 40; i++) begin
      wave[i] = tx_a;
      @(negedge clk);
    end
  endtask

  function automatic logic [39:0] expand(input logic [9:0] seq);
    logic [39:0] e;
    for (int i = 0; i < 40; i++) e[i] = seq[i / 4];
    return e;
  endfunction

  function automatic logic [7:0] decode(input logic [39:0] w);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) d[k] = w[(k + 1) * 4 + 2];
    return d;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;   // bit i = tx level during bit period i (0 = start, 9 = stop)
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [39:0] w;
    int wc, bp, bb, low, high, frame;
    bit to, flag;
    logic [7:0] exp_b2b [3];

    vecs[0] = '{8'h23, 10'b1001000110};
    vecs[1] = '{8'h3C, 10'b1001111000};
    vecs[2] = '{8'h80, 10'b1100000000};
    vecs[3] = '{8'h01, 10'b1000000010};

    // Reset held two cycles with an empty FIFO
    flag = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || ifa.rd !== 1'b0 || busy_a !== 1'b0) flag = 1'b1;
    end
    check("rst_outputs_held", flag, 1'b0);
    i_rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || ifa.rd !== 1'b0 || busy_a !== 1'b0) flag = 1'b1;
    end
    check("rst_idle_after", flag, 1'b0);
    check("rst_no_pop", pops_a, 0);

    // Single frames from the vector table
    foreach (vecs[v]) begin
      bp = pops_a;
      bb = busy_cyc_a;
      push_a(vecs[v].data);
      capture(w, wc, to);
      check("vec_timeout", to, 1'b0);
      check("vec_latency", wc, 2);
      check("vec_wave", w, expand(vecs[v].seq));
      check("vec_byte", decode(w), vecs[v].data);
      repeat (4) @(negedge clk);
      check("vec_pops", pops_a - bp, 1);
      check("vec_busy_cycles", busy_cyc_a - bb, 41);
    end

    // Back-to-back frames: 2 tx-high cycles between stop end and next start
    exp_b2b[0] = 8'h15; exp_b2b[1] = 8'h11; exp_b2b[2] = 8'h22;
    bp = pops_a;
    push_a(8'h15); push_a(8'h11); push_a(8'h22);
    for (int k = 0; k < 3; k++) begin
      capture(w, wc, to);
      check("b2b_timeout", to, 1'b0);
      check("b2b_gap", wc, 2);
      check("b2b_byte", decode(w), exp_b2b[k]);
    end
    repeat (4) @(negedge clk);
    check("b2b_pops", pops_a - bp, 3);

    // en low holds off popping; en drop mid-frame finishes the frame only
    en_a = 1'b0;
    push_a(8'h55); push_a(8'h11);
    bp = pops_a;
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || ifa.rd !== 1'b0) flag = 1'b1;
    end
    check("en0_hold", flag, 1'b0);
    check("en0_no_pop", pops_a - bp, 0);
    en_a = 1'b1;
    @(negedge clk);
    check("en1_pop_1cyc", ifa.rd, 1'b1);
    fork
      capture(w, wc, to);
      begin
        repeat (12) @(negedge clk);
        en_a = 1'b0;
      end
    join
    check("en_frame_timeout", to, 1'b0);
    check("en_frame_byte", decode(w), 8'h55);
    flag = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx_a !== 1'b1) flag = 1'b1;
    end
    check("en_off_tx_idle", flag, 1'b0);
    check("en_off_single_pop", pops_a - bp, 1);
    en_a = 1'b1;
    capture(w, wc, to);
    check("en_resume_byte", decode(w), 8'h11);

    // Reset during data bit 3 of 0xA5; 0x3C must follow intact
    push_a(8'hA5); push_a(8'h3C);
    wc = 0;
    while (tx_a !== 1'b0 && wc < 300) begin
      @(negedge clk);
      wc++;
    end
    check("rst_mid_start_seen", (wc < 300), 1'b1);
    repeat (17) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", tx_a, 1'b1);
    check("rst_mid_busy", busy_a, 1'b0);
    i_rst = 1'b0;
    bp = pops_a;
    capture(w, wc, to);
    check("rst_next_timeout", to, 1'b0);
    check("rst_next_byte", decode(w), 8'h3C);
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx_a !== 1'b1) flag = 1'b1;
    end
    check("rst_no_resend", flag, 1'b0);
    check("rst_pops", pops_a - bp, 1);

    // 5 clk/bit, 2 stop bits, byte 0xFF
    mem_b[wp_b] = 8'hFF;
    wp_b = wp_b + 6'd1;
    wc = 0;
    while (tx_b !== 1'b0 && wc < 300) begin
      @(negedge clk);
      wc++;
    end
    check("sb2_start_seen", (wc < 300), 1'b1);
    low = 0; high = 0; frame = 0;
    while (busy_b === 1'b1 && frame < 200) begin
      if (tx_b === 1'b0) low++;
      else high++;
      frame++;
      @(negedge clk);
    end
    check("sb2_low_cycles", low, 5);
    check("sb2_high_cycles", high, 50);
    check("sb2_frame_cycles", frame, 55);
    check("sb2_pops", pops_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
